// File: rtl/vote_pkg.sv
// Shared definitions for the vote tally recorder: FSM state encoding and
// default sizing constants.
package vote_pkg;

    // Default sizing for a four-candidate booth with 8-bit tallies.
    localparam int DEF_NUM_CAND    = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOCK_CYCLES = 16;

    // Recorder FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as one candidate tally. It counts on inc and
// holds at the all-ones value. at_max flags that the ceiling has been reached.
module sat_counter
    import vote_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Increment unless already pinned at the ceiling.
    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != MAX_VAL)) begin
            count_next = count_reg + W'(1);
        end
    end

    // Tally register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == MAX_VAL);

endmodule

// File: rtl/vote_tally_recorder.sv
// Vote tally recorder: accepts one one-hot vote per armed ballot, locks out
// further input for a fixed number of cycles, and offers a registered
// readout of any tally in result mode.
module vote_tally_recorder
    import vote_pkg::*;
#(
    parameter int NUM_CAND    = DEF_NUM_CAND,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ballot_en,
    input  logic                                 mode,
    input  logic [NUM_CAND-1:0]                  valid_vote,
    input  logic [$clog2(NUM_CAND)-1:0]          sel,
    output logic                                 ready,
    output logic                                 vote_ack,
    output logic                                 vote_reject,
    output logic [CNT_W-1:0]                     result_out,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]    total_votes,
    output logic                                 sat
);

    localparam int TOT_W = CNT_W + $clog2(NUM_CAND);
    // One spare bit so LOCK_CYCLES itself is representable for any value.
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);

    logic [1:0]       state_reg,  state_next;
    logic [LCK_W-1:0] lock_reg,   lock_next;
    logic [TOT_W-1:0] total_reg,  total_next;
    logic [CNT_W-1:0] result_reg, result_next;
    logic             ready_reg,  ready_next;
    logic             ack_reg,    ack_next;
    logic             rej_reg,    rej_next;
    logic             sat_reg,    sat_next;

    logic [NUM_CAND-1:0]            inc_vec;
    logic [NUM_CAND-1:0]            at_max_vec;
    logic [NUM_CAND-1:0][CNT_W-1:0] tally;

    logic vote_any;
    logic vote_multi;
    logic vote_onehot;
    logic sel_in_range;

    // One tally per candidate; only the accepted candidate's bit increments.
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
        sat_counter #(
            .W(CNT_W)
        ) u_tally (
            .clk    (clk),
            .reset  (reset),
            .inc    (inc_vec[gi]),
            .count  (tally[gi]),
            .at_max (at_max_vec[gi])
        );
    end

    // x & (x-1) clears the lowest set bit, so anything left means two or more bits.
    always_comb begin
        vote_any    = |valid_vote;
        vote_multi  = |(valid_vote & (valid_vote - NUM_CAND'(1)));
        vote_onehot = vote_any && !vote_multi;
    end

    // Out-of-range selects read back as zero rather than aliasing a tally.
    always_comb begin
        sel_in_range = (int'(sel) < NUM_CAND);
    end

    // Next-state logic: FSM transitions, vote acceptance and lockout timing.
    always_comb begin
        state_next = state_reg;
        lock_next  = lock_reg;
        total_next = total_reg;
        inc_vec    = '0;
        ack_next   = 1'b0;
        rej_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Readout request wins over an arm request.
                if (mode) begin
                    state_next = ST_RESULT;
                end else if (ballot_en) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vote_onehot) begin
                    inc_vec    = valid_vote;
                    total_next = total_reg + TOT_W'(1);
                    ack_next   = 1'b1;
                    lock_next  = '0;
                    state_next = ST_LOCK;
                end else if (vote_multi) begin
                    rej_next = 1'b1;
                end
            end
            ST_LOCK: begin
                if (lock_reg == LOCK_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    lock_next = lock_reg + LCK_W'(1);
                end
            end
            ST_RESULT: begin
                if (!mode) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output pre-computation so every port comes straight from a flop.
    always_comb begin
        ready_next  = (state_next == ST_ARMED);
        sat_next    = sat_reg | (|at_max_vec);
        result_next = '0;
        if ((state_reg == ST_RESULT) && mode && sel_in_range) begin
            result_next = tally[sel];
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            lock_reg   <= '0;
            total_reg  <= '0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
            ack_reg    <= 1'b0;
            rej_reg    <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lock_reg   <= lock_next;
            total_reg  <= total_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
            ack_reg    <= ack_next;
            rej_reg    <= rej_next;
            sat_reg    <= sat_next;
        end
    end

    assign ready       = ready_reg;
    assign vote_ack    = ack_reg;
    assign vote_reject = rej_reg;
    assign result_out  = result_reg;
    assign total_votes = total_reg;
    assign sat         = sat_reg;

endmodule
